bc_issue_ctrl: RTL
==================

# bc_issue_ctrl

Issue controller between the ID stage and EX stage of the BureCore pipeline. It keeps a per-register scoreboard of in-flight destination writes and stalls ID on RAW/WAW hazards. It sequences a fixed-length flush after taken branches and jumps. It also gates the ID→EX handshake and counts stall cycles for performance monitoring.

## Interface
Parameters:
- NREGS, 32, number of architectural integer registers; x0 is never tracked.
- FLUSH_CYCLES, 2, cycles in FLUSH state after a redirect; range 1..7.
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous, active-low reset
- i_id_valid  in  1  ID holds a decoded instruction
- i_id_rs1_addr  in  5  source register 1
- i_id_rs1_used  in  1  instruction reads rs1
- i_id_rs2_addr  in  5  source register 2
- i_id_rs2_used  in  1  instruction reads rs2
- i_id_rd_wen  in  1  instruction writes rd
- i_id_rd_addr  in  5  destination register
- i_ex_ready  in  1  EX can accept an instruction this cycle
- i_wb_valid  in  1  writeback retires a register write
- i_wb_rd_addr  in  5  register being written back
- i_redirect  in  1  EX resolved a taken branch or jump this cycle
- o_id_ready  out  1  ID instruction is consumed this cycle; ID holds when low
- o_issue_valid  out  1  EX captures the ID outputs this cycle
- o_flush  out  1  squash IF and ID contents
- o_busy  out  1  at least one scoreboard bit is set
- o_stall_cnt  out  CNT_WIDTH  cycles with i_id_valid high and no issue, flush cycles excluded

## Operation
- States are RUN and FLUSH. Reset state is RUN.
- Hazard occurs when any of the following is true:
  - rs1_used, rs1≠0, and sb[rs1] is set.
  - rs2_used, rs2≠0, and sb[rs2] is set.
  - rd_wen, rd≠0, and sb[rd] is set. This is the WAW case.
- fire = i_id_valid & i_ex_ready & ~hazard & (state==RUN) & ~i_redirect.
- o_issue_valid = fire and o_id_ready = fire. Both are combinational.
- On fire with rd_wen and rd≠0, sb[rd] is set at the next edge.
- On i_wb_valid with rd≠0, sb[rd] is cleared at the next edge.
- If the same register is set and cleared in the same cycle, the set wins.
- i_wb_valid on a register whose bit is clear is ignored; there is no error.
- Redirect handling:
  - In any state, i_redirect moves the block to FLUSH and loads the flush counter with FLUSH_CYCLES-1.
  - o_flush = i_redirect | (state==FLUSH).
  - In FLUSH, the counter decrements each cycle. At 0 with no redirect, the block returns to RUN.
  - A redirect in FLUSH reloads the counter.
- The scoreboard is untouched by a flush. All scoreboarded instructions are older than the redirecting branch.
- o_stall_cnt increments when i_id_valid, ~fire, and ~o_flush are all true. It saturates at all-ones.
- o_busy = |sb. It comes directly from registers.

## Timing
- Reset values:
  - sb = 0, state = RUN, flush counter = 0, o_stall_cnt = 0.
  - o_flush = 0, o_busy = 0, o_id_ready = 0, o_issue_valid = 0.
- Issue has zero latency: the ID→EX decision is made in the same cycle as i_id_valid.
- Scoreboard updates are visible to the hazard check one cycle after the edge.
- Redirect at cycle T:
  - o_flush is high for cycles T..T+FLUSH_CYCLES.
  - The earliest issue is T+FLUSH_CYCLES+1.
- Back-to-back dependent ALU ops stall until writeback clears the bit. The dependent op issues in the cycle after i_wb_valid, or in the same cycle with bypass (see Configuration).
- Reset asserted mid-operation clears all state asynchronously. The stall counter is also cleared.

## Configuration
- BC_ISSUE_WB_BYPASS_EN
  - Defined: a register being cleared by i_wb_valid in the current cycle is treated as not pending in the hazard check. This requires a write-through register file and saves one stall cycle per dependency.
  - Undefined: the hazard check uses registered sb only.

## Structure
- Shared package BC_ctrl_pkg holds:
  - the state enum issue_state_e {RUN, FLUSH};
  - reg_addr_t (logic [4:0]);
  - the constant REG_ZERO = 5'd0.
- Sub-module bc_scoreboard holds the NREGS-1 bit vector with set/clear ports, a 3-read lookup (rs1, rs2, rd) and the busy flag. bc_issue_ctrl contains the FSM, the flush counter and the stall counter.

## Test plan
- Independent stream: add x1 then add x2 reading x3, with i_ex_ready=1. Expect o_issue_valid in consecutive cycles and o_stall_cnt=0.
- RAW hazard:
  - Issue rd=x5, then hold a valid instruction with rs1=x5. Expect the stall to last until i_wb_valid with rd=5.
  - Bypass undefined: issue happens on the cycle after wb.
  - Bypass defined: issue happens on the same cycle as wb.
  - o_stall_cnt equals the number of stalled cycles.
- x0 and unused operands: rd=x0 issues, then a reader of x0 issues without stall. rs2=x5 with rs2_used=0 does not stall while sb[5] is set.
- Redirect with FLUSH_CYCLES=2 at cycle 10 while ID is valid:
  - No issue at 10.
  - o_flush is high for cycles 10–12.
  - Issue resumes at 13.
  - A second redirect at 11 extends o_flush through 13.
- Same-cycle set and clear of x7 (bypass defined): sb[7] stays 1 and o_busy stays 1.
- Asynchronous reset mid-stall with sb nonzero: all outputs go to 0 immediately, and the first instruction after reset issues without stall.

Source files
------------

// File: rtl/BC_ctrl_pkg.sv
// Shared types and constants for the BureCore issue-control slice.
package BC_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } issue_state_e;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/bc_scoreboard.sv
// Pending-write scoreboard (x0 never tracked) with three lookups and a busy flag.
// Optional build macro BC_ISSUE_WB_BYPASS_EN lets a same-cycle writeback hide its register.
module bc_scoreboard
  import BC_ctrl_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  reg_addr_t rd_addr,
  output logic      rs1_pend,
  output logic      rs2_pend,
  output logic      rd_pend,
  output logic      busy
);

  logic [NREGS-1:1] sb;
  logic [NREGS-1:0] sb_full;
  logic [NREGS-1:0] live;

  // A set and a clear of the same register in one cycle leave the bit set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (set_en && set_addr == reg_addr_t'(i)) begin
          sb[i] <= 1'b1;
        end else if (clr_en && clr_addr == reg_addr_t'(i)) begin
          sb[i] <= 1'b0;
        end
      end
    end
  end

  assign sb_full = {sb, 1'b0};

`ifdef BC_ISSUE_WB_BYPASS_EN
  always_comb begin
    live = sb_full;
    if (clr_en) begin
      live[clr_addr] = 1'b0;
    end
  end
`else
  assign live = sb_full;
`endif

  assign rs1_pend = live[rs1_addr];
  assign rs2_pend = live[rs2_addr];
  assign rd_pend  = live[rd_addr];
  assign busy     = |sb;

endmodule

// File: rtl/bc_issue_ctrl.sv
// ID->EX issue controller: hazard stall, post-redirect flush sequencing, stall counter.
// Build macro BC_ISSUE_WB_BYPASS_EN (see bc_scoreboard) removes one stall cycle per dependency.
module bc_issue_ctrl
  import BC_ctrl_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_id_valid,
  input  logic [4:0]           i_id_rs1_addr,
  input  logic                 i_id_rs1_used,
  input  logic [4:0]           i_id_rs2_addr,
  input  logic                 i_id_rs2_used,
  input  logic                 i_id_rd_wen,
  input  logic [4:0]           i_id_rd_addr,
  input  logic                 i_ex_ready,
  input  logic                 i_wb_valid,
  input  logic [4:0]           i_wb_rd_addr,
  input  logic                 i_redirect,
  output logic                 o_id_ready,
  output logic                 o_issue_valid,
  output logic                 o_flush,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  issue_state_e state_q, state_d;
  logic [2:0]   flush_cnt_q, flush_cnt_d;
  logic         rs1_pend, rs2_pend, rd_pend;
  logic         hazard, fire, flush, stall_inc;
  logic         set_en, clr_en;

  assign set_en = fire && i_id_rd_wen && (i_id_rd_addr != REG_ZERO);
  assign clr_en = i_wb_valid && (i_wb_rd_addr != REG_ZERO);

  bc_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .set_en   (set_en),
    .set_addr (i_id_rd_addr),
    .clr_en   (clr_en),
    .clr_addr (i_wb_rd_addr),
    .rs1_addr (i_id_rs1_addr),
    .rs2_addr (i_id_rs2_addr),
    .rd_addr  (i_id_rd_addr),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .busy     (o_busy)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Handshake outputs are gated by reset so they read low while i_rstn is held.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    hazard      = (i_id_rs1_used && rs1_pend) ||
                  (i_id_rs2_used && rs2_pend) ||
                  (i_id_rd_wen   && rd_pend);
    fire        = i_rstn && i_id_valid && i_ex_ready && !hazard &&
                  (state_q == RUN) && !i_redirect;
    flush       = i_rstn && (i_redirect || (state_q == FLUSH));
    stall_inc   = i_id_valid && !fire && !flush;
    if (i_redirect) begin
      state_d     = FLUSH;
      flush_cnt_d = 3'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      if (flush_cnt_q == 3'd0) begin
        state_d = RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end
  end

  assign o_issue_valid = fire;
  assign o_id_ready    = fire;
  assign o_flush       = flush;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
    end else if (stall_inc && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
